// File: rtl/trap_ctrl.sv
// trap_ctrl: sequences synchronous exceptions, interrupts and mret into a trap pulse
// followed by a fetch redirect. Interrupt support is compiled in with `define TRAP_CTRL_IRQ_EN.
module trap_ctrl #(
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_addr,
   input  logic        insn_misaligned,
   input  logic        illegal_insn,
   input  logic        ebreak,
   input  logic        ecall,
   input  logic        load_misaligned,
   input  logic        store_misaligned,
   input  logic        mret,
   input  logic        ext_irq,
   input  logic        irq_en,
   input  logic [31:0] mtvec_rdata,
   input  logic [31:0] mepc_rdata,
   output logic        trap,
   output logic [4:0]  trap_src,
   output logic [31:0] trap_pc,
   output logic [31:0] trap_addr,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic        pipe_flush,
   output logic        busy,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_TRAP     = 2'd1,
      S_WAIT     = 2'd2,
      S_REDIRECT = 2'd3
   } state_t;

   localparam logic [1:0] CNT_LOAD = 2'(WAIT_CYCLES - 1);

   state_t      r_state;
   logic [1:0]  r_cnt;
   logic        r_trap;
   logic [4:0]  r_trap_src;
   logic [31:0] r_trap_pc;
   logic [31:0] r_trap_addr;
   logic        r_redirect;
   logic [31:0] r_redirect_pc;
   logic        r_pipe_flush;
   logic        r_busy;

   logic        w_exc;
   logic [3:0]  w_code;
   logic        w_zero_addr;
   logic        w_irq;
   logic        w_take;
   logic        w_unused;

   // Exception priority encoder; ebreak/ecall carry no meaningful address.
   always_comb begin
      w_exc       = 1'b1;
      w_code      = 4'd0;
      w_zero_addr = 1'b0;
      if (insn_misaligned) begin
         w_code = 4'd0;
      end else if (illegal_insn) begin
         w_code = 4'd2;
      end else if (ebreak) begin
         w_code      = 4'd3;
         w_zero_addr = 1'b1;
      end else if (ecall) begin
         w_code      = 4'd11;
         w_zero_addr = 1'b1;
      end else if (load_misaligned) begin
         w_code = 4'd4;
      end else if (store_misaligned) begin
         w_code = 4'd6;
      end else begin
         w_exc = 1'b0;
      end
   end

`ifdef TRAP_CTRL_IRQ_EN
   assign w_irq    = ext_irq & irq_en & ~w_exc;
   assign w_unused = ^mtvec_rdata[1:0];
`else
   assign w_irq    = 1'b0;
   assign w_unused = ^{ext_irq, irq_en, mtvec_rdata[1:0]};
`endif

   assign w_take = ex_valid & (w_exc | w_irq);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_cnt         <= 2'd0;
         r_trap        <= 1'b0;
         r_trap_src    <= 5'd0;
         r_trap_pc     <= 32'd0;
         r_trap_addr   <= 32'd0;
         r_redirect    <= 1'b0;
         r_redirect_pc <= 32'd0;
         r_pipe_flush  <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_trap        <= 1'b0;
         r_redirect    <= 1'b0;
         r_pipe_flush  <= 1'b0;
         r_redirect_pc <= 32'd0;
         case (r_state)
            S_IDLE: begin
               if (w_take) begin
                  r_state     <= S_TRAP;
                  r_trap      <= 1'b1;
                  r_busy      <= 1'b1;
                  r_trap_src  <= w_exc ? {1'b0, w_code} : 5'h1B;
                  r_trap_pc   <= ex_pc;
                  r_trap_addr <= (w_zero_addr || !w_exc) ? 32'd0 : ex_addr;
               end else if (ex_valid && mret) begin
                  r_state       <= S_REDIRECT;
                  r_redirect    <= 1'b1;
                  r_pipe_flush  <= 1'b1;
                  r_redirect_pc <= mepc_rdata;
                  r_busy        <= 1'b1;
               end
            end
            S_TRAP: begin
               r_state <= S_WAIT;
               r_cnt   <= CNT_LOAD;
            end
            S_WAIT: begin
               // Counter reaching zero ends the last idle cycle.
               if (r_cnt == 2'd0) begin
                  r_state       <= S_REDIRECT;
                  r_redirect    <= 1'b1;
                  r_pipe_flush  <= 1'b1;
                  r_redirect_pc <= {mtvec_rdata[31:2], 2'b00};
               end else begin
                  r_cnt <= r_cnt - 2'd1;
               end
            end
            S_REDIRECT: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign trap        = r_trap;
   assign trap_src    = r_trap_src;
   assign trap_pc     = r_trap_pc;
   assign trap_addr   = r_trap_addr;
   assign redirect    = r_redirect;
   assign redirect_pc = r_redirect_pc;
   assign pipe_flush  = r_pipe_flush;
   assign busy        = r_busy;
   assign dbg_state   = r_state;

endmodule
